// File: rtl/d_latch_cell_pkg.sv
// Shared constants for the d_latch_cell block.
package d_latch_cell_pkg;

  // Default data path width of the latch cell.
  localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/d_latch_cell.sv
// Level-sensitive D latch with enable and gate-qualified synchronous reset.
// clk is the latch gate: transparent while high, holding while low.
module d_latch_cell
  import d_latch_cell_pkg::*;
#(
  parameter int unsigned         WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH-1:0] q_q;

  // Storage: reset wins over enable, and both only act while the gate is open.
  always_latch begin
    if (clk) begin
      if (rst) begin
        q_q <= RESET_VALUE;
      end else if (en) begin
        q_q <= d;
      end
    end
  end

  assign q = q_q;

  // Complement is derived, not stored, so it can never disagree with q.
  assign q_n = ~q_q;

endmodule

// File: tb/tb_d_latch_cell.sv
// Directed self-checking bench for d_latch_cell (1-bit and 8-bit instances).
module tb_d_latch_cell;

  logic       clk;
  logic       rst1, en1;
  logic [0:0] d1, q1, qn1;
  logic       rst8, en8;
  logic [7:0] d8, q8, qn8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  d_latch_cell #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) u_dut1 (
    .clk(clk),
    .rst(rst1),
    .en (en1),
    .d  (d1),
    .q  (q1),
    .q_n(qn1)
  );

  d_latch_cell #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) u_dut8 (
    .clk(clk),
    .rst(rst8),
    .en (en8),
    .d  (d8),
    .q  (q8),
    .q_n(qn8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic e);
    check({tag, ".q"}, {7'b0, q1}, {7'b0, e});
    check({tag, ".q_n"}, {7'b0, qn1}, {7'b0, ~e});
  endtask

  task automatic chk8(input string tag, input logic [7:0] e);
    check({tag, ".q"}, q8, e);
    check({tag, ".q_n"}, qn8, ~e);
  endtask

  initial begin
    // t=0: gate closed, 1-bit lane enabled with d=1
    clk = 1'b0; rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h11;

    #5 clk = 1'b1;                 // t=5 gate opens
    #1 chk1("w1_transparent_d1", 1'b1);
    chk8("w8_transparent_11", 8'h11);
    #9 clk = 1'b0;                 // t=15 gate closes
    #5 chk1("w1_hold_t20", 1'b1);  // t=20

    d1 = 1'b0;
    d8 = 8'hFF;
    #2 chk1("w1_closed_ignores_d", 1'b1);
    chk8("w8_closed_ignores_d", 8'h11);
    #3 clk = 1'b1;                 // t=25
    #1 chk1("w1_next_high_d0", 1'b0);
    chk8("w8_next_high_ff", 8'hFF);
    #9 clk = 1'b0;                 // t=35
    #5 chk1("w1_hold_t40", 1'b0);  // t=40

    // Multiple d changes inside one high phase
    #5 clk = 1'b1;                 // t=45
    #1 chk1("w1_toggle_0", 1'b0);
    d1 = 1'b1;
    #1 chk1("w1_toggle_1", 1'b1);
    d1 = 1'b0;
    d8 = 8'h5A;
    #1 chk1("w1_toggle_back_0", 1'b0);
    chk8("w8_track_5a", 8'h5A);
    #2 clk = 1'b0;                 // t=50
    #2 d1 = 1'b1;
    d8 = 8'h00;
    #1 chk1("w1_fall_retains_0", 1'b0);
    chk8("w8_fall_retains_5a", 8'h5A);

    // Enable low while transparent holds the prior value
    #2 clk = 1'b1;                 // t=55, d1=1
    #1 chk1("w1_load_1", 1'b1);
    en1 = 1'b0;
    en8 = 1'b0;
    #1 d1 = 1'b0;
    d8 = 8'hC3;
    #1 chk1("w1_en0_hold", 1'b1);
    chk8("w8_en0_hold", 8'h00);
    #2 clk = 1'b0;                 // t=60
    #2 chk1("w1_en0_after_fall", 1'b1);

    // Reset while gate closed is ignored
    rst1 = 1'b1;
    rst8 = 1'b1;
    #1 chk1("w1_rst_closed_ignored", 1'b1);
    chk8("w8_rst_closed_ignored", 8'h00);
    #2 clk = 1'b1;                 // t=65, en still 0: reset beats enable
    #1 chk1("w1_rst_open", 1'b0);
    chk8("w8_rst_open_a5", 8'hA5);
    #4 clk = 1'b0;                 // t=70
    #1 rst8 = 1'b0;
    rst1 = 1'b0;
    en8 = 1'b1;
    d8 = 8'h77;
    #1 chk8("w8_rst_held_after_fall", 8'hA5);

    // Reset release within one high phase returns to transparency
    rst8 = 1'b1;
    d8 = 8'h3C;
    #3 clk = 1'b1;                 // t=75
    #1 chk8("w8_rst_priority_over_d", 8'hA5);
    rst8 = 1'b0;
    #1 chk8("w8_rst_release_3c", 8'h3C);
    #3 clk = 1'b0;                 // t=80
    #2 d8 = 8'h81;
    #1 chk8("w8_final_hold_3c", 8'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/d_latch_cell.md
D_LATCH_CELL -- requirements
Module: d_latch_cell

Interface
REQ-001 Parameter: WIDTH, 1, data path width in bits (legal range 1..64).
REQ-002 Parameter: RESET_VALUE, all zeros, value loaded into q on reset, WIDTH bits.
REQ-003 Port: clk  input  1  level-sensitive latch gate; transparent while high; the block's only clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset; acts only while clk is high.
REQ-005 Port: en  input  1  latch enable; when low, q holds even while clk is high.
REQ-006 Port: d  input  WIDTH  data input.
REQ-007 Port: q  output  WIDTH  latched data output.
REQ-008 Port: q_n  output  WIDTH  bitwise complement of q at all times.

Function
REQ-009 While clk=1, rst=0 and en=1, q SHALL follow d combinationally (transparent, zero-cycle latency).
REQ-010 While clk=0, q SHALL hold the value present at the falling edge of clk, regardless of d, en or rst.
REQ-011 While clk=1 and en=0 (rst=0), q SHALL hold its current value.
REQ-012 While clk=1 and rst=1, q SHALL equal RESET_VALUE, taking priority over en and d.
REQ-013 d changes during clk=1 (en=1, rst=0) SHALL propagate to q immediately, and the last value before clk falls SHALL be retained.
REQ-014 Simultaneous d and clk falling transitions: the design is undefined here; benches SHALL keep d stable around the falling edge.
REQ-015 q_n SHALL always equal ~q, with no extra storage element.
REQ-016 All WIDTH bits SHALL behave identically and independently.
REQ-017 Before the first reset, q SHALL be X in simulation; no initial-value assignment.

Reset
REQ-018 Reset SHALL be sampled only during the transparent phase (clk=1); rst=1 while clk=0 SHALL NOT change q.
REQ-019 q SHALL equal RESET_VALUE from the moment clk=1 with rst=1, and SHALL hold it after clk falls.
REQ-020 Deasserting rst while clk=1 with en=1 SHALL return q to following d in the same phase.

Structure
REQ-021 The design SHALL be one module with a single level-sensitive storage process (always_latch or equivalent) and a continuous assign for q_n.
REQ-022 The design SHALL contain no sub-modules; a shared package is not required. If the team package exists, it MAY hold the WIDTH default constant.
REQ-023 The design SHALL NOT contain any edge-triggered flops; synthesis SHALL infer latches only for q.

Verification
REQ-024 clk=0, d=1 (WIDTH=1, en=1, rst=0), then clk rises -> q=1 within the high phase; after clk falls, q remains 1 (check at t=20).
REQ-025 Then d=0 while clk=0 -> q stays 1; at the next clk high, q=0 and remains 0 after the fall (check at t=40).
REQ-026 clk=1, en=1, d toggles 0->1->0 within one high phase -> q tracks each value; clk falls with d=0 -> q holds 0.
REQ-027 clk=1, en=0, d changes 1->0 -> q keeps its prior value of 1.
REQ-028 rst=1 asserted while clk=0 -> q unchanged; clk rises -> q=RESET_VALUE (test with WIDTH=8, RESET_VALUE=8'hA5); rst drops while clk=1, d=8'h3C -> q=8'h3C.
REQ-029 In every scenario, check q_n == ~q continuously.
